// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - N-channel registered mux with fixed/round-robin select and valid/ready handshakes
module rr_mux_reg #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_chan
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             free;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [N-1:0]     grant_oh;
  logic [W-1:0]     grant_data;
  logic             take;

  assign free = (state_q == EMPTY) | out_ready;

  // Round-robin: first requester above last wins, otherwise the lowest requester
  // (which covers the wrap back through channel last itself).
  always_comb begin
    logic             hi_vld, lo_vld, fix_vld;
    logic [SEL_W-1:0] hi_idx, lo_idx, fix_idx;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    fix_vld = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    fix_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (in_valid[j]) begin
        if ((j > int'(last_q)) && !hi_vld) begin
          hi_vld = 1'b1;
          hi_idx = SEL_W'(j);
        end
        if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_idx = SEL_W'(j);
        end
        if (int'(sel) == j) begin
          fix_vld = 1'b1;
          fix_idx = SEL_W'(j);
        end
      end
    end
    if (mode) begin
      grant_vld = hi_vld | lo_vld;
      grant_idx = hi_vld ? hi_idx : lo_idx;
    end else begin
      grant_vld = fix_vld;
      grant_idx = fix_idx;
    end
  end

  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int j = 0; j < N; j++) begin
      if (grant_vld && (int'(grant_idx) == j)) begin
        grant_oh[j] = 1'b1;
        grant_data  = in_data[j*W +: W];
      end
    end
  end

  // Gated by rst so the handshake is dead for as long as reset is held.
  assign in_ready = (free && !rst) ? grant_oh : '0;
  assign take     = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    if (free) begin
      if (take) begin
        state_d = FULL;
        data_d  = grant_data;
        chan_d  = grant_idx;
        last_d  = grant_idx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= SEL_W'(N - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - directed table-driven bench for rr_mux_reg (N=4 and N=3 instances)
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode_a, out_ready_a, out_valid_a;
  logic [1:0]  sel_a, out_chan_a;
  logic [15:0] in_data_a;
  logic [3:0]  in_valid_a, in_ready_a, out_data_a;

  logic        mode_b, out_ready_b, out_valid_b;
  logic [1:0]  sel_b, out_chan_b;
  logic [11:0] in_data_b;
  logic [2:0]  in_valid_b, in_ready_b;
  logic [3:0]  out_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_reg #(.N(4), .W(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .mode(mode_a), .sel(sel_a),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_chan(out_chan_a)
  );

  rr_mux_reg #(.N(3), .W(4), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .mode(mode_b), .sel(sel_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_chan(out_chan_b)
  );

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        rdy;
    logic [15:0] data;
    logic [3:0]  ir;
    logic        ov;
    logic [3:0]  od;
    logic [1:0]  oc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                              input logic r, input logic [15:0] d, input logic [3:0] ir,
                              input logic ov, input logic [3:0] od, input logic [1:0] oc);
    vec_t t;
    t.mode = m; t.sel = s; t.vld = v; t.rdy = r; t.data = d;
    t.ir = ir; t.ov = ov; t.od = od; t.oc = oc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs driven just after a posedge; in_ready checked at negedge, registers after next posedge.
  task automatic apply_a(input vec_t t, input int idx);
    mode_a = t.mode; sel_a = t.sel; in_valid_a = t.vld; out_ready_a = t.rdy; in_data_a = t.data;
    @(negedge clk);
    check($sformatf("a[%0d] in_ready", idx), 32'(in_ready_a), 32'(t.ir));
    @(posedge clk);
    #1;
    check($sformatf("a[%0d] out_valid", idx), 32'(out_valid_a), 32'(t.ov));
    check($sformatf("a[%0d] out_data", idx), 32'(out_data_a), 32'(t.od));
    check($sformatf("a[%0d] out_chan", idx), 32'(out_chan_a), 32'(t.oc));
  endtask

  task automatic apply_b(input string nm, input logic m, input logic [1:0] s, input logic [2:0] v,
                         input logic r, input logic [2:0] ir, input logic ov,
                         input logic [3:0] od, input logic [1:0] oc);
    mode_b = m; sel_b = s; in_valid_b = v; out_ready_b = r;
    @(negedge clk);
    check({nm, " in_ready"}, 32'(in_ready_b), 32'(ir));
    @(posedge clk);
    #1;
    check({nm, " out_valid"}, 32'(out_valid_b), 32'(ov));
    check({nm, " out_data"}, 32'(out_data_b), 32'(od));
    check({nm, " out_chan"}, 32'(out_chan_b), 32'(oc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    localparam logic [15:0] D0 = 16'h7521;
    localparam logic [15:0] D8 = 16'h8521;

    rst = 1'b1;
    mode_a = 1'b0; sel_a = 2'd0; in_valid_a = 4'b0000; out_ready_a = 1'b1; in_data_a = D0;
    mode_b = 1'b0; sel_b = 2'd0; in_valid_b = 3'b000;  out_ready_b = 1'b1; in_data_b = 12'h963;

    #1;
    check("reset out_valid", 32'(out_valid_a), 32'd0);
    check("reset out_data", 32'(out_data_a), 32'd0);
    check("reset out_chan", 32'(out_chan_a), 32'd0);
    check("reset in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    //                mode  sel   valid    rdy   data ir       ov    od     oc
    tbl.push_back(mk(1'b0, 2'd0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 4'd1, 2'd0));
    tbl.push_back(mk(1'b0, 2'd1, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 4'd2, 2'd1));
    tbl.push_back(mk(1'b0, 2'd2, 4'b1111, 1'b1, D0, 4'b0100, 1'b1, 4'd5, 2'd2));
    tbl.push_back(mk(1'b0, 2'd3, 4'b1111, 1'b1, D0, 4'b1000, 1'b1, 4'd7, 2'd3));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 4'd1, 2'd0));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 4'd2, 2'd1));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0100, 1'b1, 4'd5, 2'd2));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b1000, 1'b1, 4'd7, 2'd3));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 4'd1, 2'd0));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 4'd2, 2'd1));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, D0, 4'b1000, 1'b1, 4'd7, 2'd3));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, D0, 4'b0010, 1'b1, 4'd2, 2'd1));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, D0, 4'b1000, 1'b1, 4'd7, 2'd3));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1010, 1'b1, D0, 4'b0010, 1'b1, 4'd2, 2'd1));
    // no requester: word taken, output empties, data/chan hold
    tbl.push_back(mk(1'b1, 2'd0, 4'b0000, 1'b1, D0, 4'b0000, 1'b0, 4'd2, 2'd1));
    tbl.push_back(mk(1'b0, 2'd0, 4'b0001, 1'b1, D0, 4'b0001, 1'b1, 4'd1, 2'd0));
    // stalled: sel/mode changes must not disturb the held word or the pointer
    tbl.push_back(mk(1'b0, 2'd1, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 4'd1, 2'd0));
    tbl.push_back(mk(1'b1, 2'd1, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 4'd1, 2'd0));
    tbl.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 4'd2, 2'd1));
    tbl.push_back(mk(1'b1, 2'd0, 4'b0100, 1'b1, D0, 4'b0100, 1'b1, 4'd5, 2'd2));
    tbl.push_back(mk(1'b1, 2'd0, 4'b0100, 1'b1, D0, 4'b0100, 1'b1, 4'd5, 2'd2));
    tbl.push_back(mk(1'b1, 2'd0, 4'b0001, 1'b1, D0, 4'b0001, 1'b1, 4'd1, 2'd0));
    // backpressure with word 8 held for three cycles, then pop+push on one edge
    tbl.push_back(mk(1'b0, 2'd3, 4'b1000, 1'b1, D8, 4'b1000, 1'b1, 4'd8, 2'd3));
    tbl.push_back(mk(1'b0, 2'd0, 4'b1111, 1'b0, D8, 4'b0000, 1'b1, 4'd8, 2'd3));
    tbl.push_back(mk(1'b0, 2'd0, 4'b1111, 1'b0, D8, 4'b0000, 1'b1, 4'd8, 2'd3));
    tbl.push_back(mk(1'b0, 2'd0, 4'b1111, 1'b0, D8, 4'b0000, 1'b1, 4'd8, 2'd3));
    tbl.push_back(mk(1'b0, 2'd0, 4'b1111, 1'b1, D8, 4'b0001, 1'b1, 4'd1, 2'd0));
    tbl.push_back(mk(1'b0, 2'd2, 4'b1111, 1'b1, D0, 4'b0100, 1'b1, 4'd5, 2'd2));

    foreach (tbl[i]) apply_a(tbl[i], i);

    // asynchronous reset mid-cycle while FULL
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(out_valid_a), 32'd0);
    check("async rst out_data", 32'(out_data_a), 32'd0);
    check("async rst out_chan", 32'(out_chan_a), 32'd0);
    check("async rst in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk);
    #1;
    check("rst held out_valid", 32'(out_valid_a), 32'd0);
    rst = 1'b0;
    apply_a(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 4'd1, 2'd0), 100);
    apply_a(mk(1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 4'd2, 2'd1), 101);
    in_valid_a = 4'b0000;

    // N=3 instance: channel data ch0=3, ch1=6, ch2=9
    apply_b("b sel2",         1'b0, 2'd2, 3'b111, 1'b1, 3'b100, 1'b1, 4'd9, 2'd2);
    apply_b("b sel3 stall",   1'b0, 2'd3, 3'b111, 1'b0, 3'b000, 1'b1, 4'd9, 2'd2);
    apply_b("b sel3 drain",   1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 4'd9, 2'd2);
    apply_b("b sel3 idle",    1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 4'd9, 2'd2);
    apply_b("b sel0",         1'b0, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 4'd3, 2'd0);
    apply_b("b rr1",          1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 4'd6, 2'd1);
    apply_b("b rr2",          1'b1, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1, 4'd9, 2'd2);
    apply_b("b rr wrap",      1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 4'd3, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
